// File: rtl/cla_addsub_pipe_if.sv
// Handshake bundle for cla_addsub_pipe: operand side (in_*, a, b, cin, sub)
// and result side (out_*, sum, cout, ovf, zero); slave = block, master = user.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// Ports: clk, rst_n (async, active-low), bus (cla_addsub_pipe_if.slave).
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic              clk,
    input logic              rst_n,
    cla_addsub_pipe_if.slave bus
);
    localparam int NG = WIDTH / GROUP;

    // Expanded lookahead: carry out of bit hi given carry ci into bit lo.
    // Loops unroll into the flat sum-of-products form; no ripple chain.
    function automatic logic la(
        input logic [WIDTH-1:0] gv,
        input logic [WIDTH-1:0] pv,
        input logic             ci,
        input int               lo,
        input int               hi
    );
        logic c;
        logic t;
        c = ci;
        for (int m = lo; m <= hi; m++) c = c & pv[m];
        for (int j = lo; j <= hi; j++) begin
            t = gv[j];
            for (int m = j + 1; m <= hi; m++) t = t & pv[m];
            c = c | t;
        end
        return c;
    endfunction

    logic s1_en;
    logic s2_en;

    logic             s1_valid;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;
    logic [NG-1:0]    pg_q;
    logic [NG-1:0]    gg_q;
    logic             c0_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;
    logic [NG-1:0]    pg_d;
    logic [NG-1:0]    gg_d;
    logic             c0_d;

    logic [NG:0]      gc;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    assign s2_en        = !out_valid_q | bus.out_ready;
    assign s1_en        = !s1_valid | s2_en;
    assign bus.in_ready = s1_en;

    // Stage 1: operand conditioning plus bit and group propagate/generate.
    always_comb begin
        pg_d  = '0;
        gg_d  = '0;
        b_eff = bus.sub ? ~bus.b : bus.b;
        c0_d  = bus.sub ? 1'b1 : bus.cin;
        p_d   = bus.a ^ b_eff;
        g_d   = bus.a & b_eff;
        for (int k = 0; k < NG; k++) begin
            pg_d[k] = &p_d[k*GROUP +: GROUP];
            gg_d[k] = la(g_d, p_d, 1'b0, k * GROUP, k * GROUP + GROUP - 1);
        end
    end

    // Stage 2: group carries straight from C0, then in-group carries.
    always_comb begin
        gc    = '0;
        c     = '0;
        gc[0] = c0_q;
        for (int k = 0; k < NG; k++) begin
            gc[k+1] = la(WIDTH'(gg_q), WIDTH'(pg_q), c0_q, 0, k);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (i % GROUP == 0) c[i] = gc[i/GROUP];
            else c[i] = la(g_q, p_q, gc[i/GROUP], i - (i % GROUP), i - 1);
        end
        sum_d  = p_q ^ c;
        cout_d = gc[NG];
        ovf_d  = c[WIDTH-1] ^ cout_d;
        zero_d = ~|sum_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            p_q      <= '0;
            g_q      <= '0;
            pg_q     <= '0;
            gg_q     <= '0;
            c0_q     <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                p_q  <= p_d;
                g_q  <= g_d;
                pg_q <= pg_d;
                gg_q <= gg_d;
                c0_q <= c0_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
